// File: rtl/intermed_pkg.sv
`default_nettype none
// ============================================================================
// Module      : intermed_pkg
// Description : Mode encodings and the per-bit out_1 combine used by intermed_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
package intermed_pkg;

    localparam logic [1:0] MODE_OR   = 2'd0;
    localparam logic [1:0] MODE_XOR  = 2'd1;
    localparam logic [1:0] MODE_AND  = 2'd2;
    localparam logic [1:0] MODE_PASS = 2'd3;

    // Single-bit form; the combine is purely bitwise so callers apply it per bit.
    function automatic logic f_out1(input logic inter, input logic c, input logic [1:0] mode);
        logic r;
        case (mode)
            MODE_OR:  r = inter | c;
            MODE_XOR: r = inter ^ c;
            MODE_AND: r = inter & c;
            default:  r = c;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/intermed_stage.sv
`default_nettype none
// ============================================================================
// Module      : intermed_stage
// Description : One valid/ready pipeline slot: payload register, valid flag, load logic.
// Revision    : 1.0 - initial release
// ============================================================================
module intermed_stage
    import intermed_pkg::*;
#(
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_v,
    input  logic [DW-1:0] i_d,
    input  logic          i_adv,
    output logic          o_v,
    output logic [DW-1:0] o_d
);

    logic          r_v;
    logic [DW-1:0] r_d;
    logic          w_load;

    // Loads when empty (bubble collapse) or when the downstream slot takes our beat.
    assign w_load = !r_v || i_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v <= 1'b0;
            r_d <= '0;
        end else if (w_load) begin
            r_v <= i_v;
            if (i_v) begin
                r_d <= i_d;
            end
        end
    end

    assign o_v = r_v;
    assign o_d = r_d;

endmodule
`default_nettype wire

// File: rtl/intermed_pipe.sv
`default_nettype none
// ============================================================================
// Module      : intermed_pipe
// Description : Bitwise intermediate-term logic with a STAGES-deep valid/ready
//               pipeline and a saturating nonzero-out_2 beat counter.
// Revision    : 1.0 - initial release
// ============================================================================
module intermed_pipe
    import intermed_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_1,
    input  logic [WIDTH-1:0] in_2,
    input  logic [WIDTH-1:0] in_3,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_1,
    output logic [WIDTH-1:0] out_2,
    output logic [WIDTH-1:0] inter_out,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int DW = 3 * WIDTH;

    logic [WIDTH-1:0] w_inter;
    logic [WIDTH-1:0] w_out1;
    logic [WIDTH-1:0] w_out2;
    logic [STAGES-1:0] w_sv;
    logic [STAGES-1:0] w_sv_in;
    logic [STAGES:0]   w_load;
    logic [DW-1:0]     w_sd    [STAGES];
    logic [DW-1:0]     w_sd_in [STAGES];
    logic [CNT_W-1:0]  r_cnt;

    always_comb begin
        w_inter = in_1 & in_2;
        w_out2  = w_inter & in_2;
        w_out1  = '0;
        for (int b = 0; b < WIDTH; b++) begin
            w_out1[b] = f_out1(w_inter[b], in_3[b], mode);
        end
    end

    // Ready chain walks back from the consumer handshake; a slot frees up if it or any later slot can move.
    always_comb begin
        w_load         = '0;
        w_load[STAGES] = out_valid && out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_load[k] = !w_sv[k] || w_load[k+1];
        end
    end

    always_comb begin
        w_sv_in    = '0;
        w_sv_in[0] = in_valid;
        w_sd_in[0] = {w_inter, w_out1, w_out2};
        for (int k = 1; k < STAGES; k++) begin
            w_sv_in[k] = w_sv[k-1];
            w_sd_in[k] = w_sd[k-1];
        end
    end

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            intermed_stage #(
                .DW (DW)
            ) u_stage (
                .clk   (clk),
                .rst   (rst),
                .i_v   (w_sv_in[k]),
                .i_d   (w_sd_in[k]),
                .i_adv (w_load[k+1]),
                .o_v   (w_sv[k]),
                .o_d   (w_sd[k])
            );
        end
    endgenerate

    assign in_ready                     = w_load[0];
    assign out_valid                    = w_sv[STAGES-1];
    assign {inter_out, out_1, out_2}    = w_sd[STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (out_valid && out_ready && (|out_2) && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign match_cnt = r_cnt;

endmodule
`default_nettype wire

// File: doc/intermed_pipe.md
# intermed_pipe

Parametrised, pipelined successor to the team's single-bit intermediate-wire logic cell. It computes a vector intermediate term `inter = in_1 & in_2` and two results from it: `out_1`, combined with `in_3` under a per-beat selectable mode, and `out_2 = inter & in_2`. Data moves through a configurable-depth valid/ready pipeline with full backpressure. A saturating counter tracks accepted beats with a nonzero `out_2`. The block sits between a producer and a consumer stage in the datapath.

## Interface
- `WIDTH`, default 8: bit width of all data vectors; legal values are 1 or more.
- `STAGES`, default 2: number of pipeline register slots; legal values are 1..4.
- `CNT_W`, default 16: width of the match counter.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: the producer presents a beat.
- `in_ready` out 1: the block accepts the beat this cycle.
- `in_1`, `in_2`, `in_3` in WIDTH: operand vectors.
- `mode` in 2: `out_1` combine select, sampled together with the beat.
- `out_valid` out 1: the output beat is valid.
- `out_ready` in 1: the consumer accepts the beat.
- `out_1`, `out_2`, `inter_out` out WIDTH: results, plus the intermediate term made visible.
- `cnt_clr` in 1: synchronous clear of the match counter.
- `match_cnt` out CNT_W: saturating count of accepted beats with a nonzero `out_2`.

## Operation
- Computation happens at entry and is purely bitwise, with no carries.
  - `inter = in_1 & in_2`.
  - `out_2 = inter & in_2`.
  - `out_1` depends on `mode`: 0 gives `inter | in_3`; 1 gives `inter ^ in_3`; 2 gives `inter & in_3`; 3 gives `in_3`.
- Each slot holds {`v`, `inter`, `out_1`, `out_2`}. The last slot drives the outputs directly, so the outputs are registered and there is no combinational path from the `in_*` data inputs to the outputs.
- Advance rule: slot k loads when it is empty or when slot k+1 advances. The last slot advances on `out_valid & out_ready`.
- `in_ready` is true when slot 0 loads. It is combinational through the ready chain, which is the only combinational path in the block.
- A beat is accepted on `in_valid & in_ready`. A slot that loads with no incoming beat clears its `v`.
- Bubbles collapse: an empty slot loads even while downstream is stalled.
- Full condition: all `v`=1 and `out_ready`=0. In that case `in_ready`=0 and all slot contents hold.
- Stall: while `out_valid & !out_ready`, the values of `out_1`, `out_2` and `inter_out` stay stable.
- Counter rules:
  - `match_cnt` increments on `out_valid & out_ready & |out_2`.
  - It saturates at 2^CNT_W-1 and does not wrap.
  - `cnt_clr` clears the counter to 0 on the next edge and takes precedence over a simultaneous increment.
- Reset behaviour:
  - All `v` bits, data registers and `match_cnt` go to 0, so `out_valid`, `out_1`, `out_2`, `inter_out` and `match_cnt` all read 0 after reset.
  - `in_ready` reads 1 after reset, because the slots are empty.
  - A reset mid-operation discards in-flight beats without delivering them and without counting them.
  - While `rst`=1, `in_ready` may be 1, but no beat is taken.
- A beat with `in_valid`=0 is ignored whatever is on the data inputs.

## Timing
- Latency is exactly STAGES cycles: a beat accepted at edge N is visible on the outputs after edge N+STAGES-1, provided `out_ready` stayed 1.
- Throughput is one beat per cycle in steady state with `out_ready`=1. There are no bubbles when the pipeline is full and flowing, because accept and deliver happen in the same cycle.
- `match_cnt` updates on the edge that completes the output handshake, and the new value is visible the following cycle.
- The depth is STAGES beats. No beat is lost or duplicated across any pattern of stalls.

## Structure
- Package `intermed_pkg`:
  - mode constants `MODE_OR`=0, `MODE_XOR`=1, `MODE_AND`=2, `MODE_PASS`=3;
  - a function `f_out1(inter, c, mode)` implementing the `out_1` combine.
- Sub-module `intermed_stage`: one slot holding the register, its `v` flag and the local load logic. It is instantiated STAGES times in a generate loop.
- The top level contains the entry compute, the ready chain and the counter.

## Test plan
- Reset, then stream with WIDTH=8, STAGES=2, `out_ready`=1, `in_1`=0xF0, `in_2`=0x3C, `in_3`=0x01:
  - mode 0 gives `inter`=0x30, `out_1`=0x31, `out_2`=0x30, appearing 2 cycles after acceptance;
  - mode 1 gives `out_1`=0x31, mode 2 gives `out_1`=0x00, mode 3 gives `out_1`=0x01.
- Backpressure: push 5 beats with `out_ready`=0.
  - `in_ready` drops after 2 beats are accepted.
  - Outputs hold the first beat, stable.
  - Release `out_ready`; the beats arrive in order, none lost, none duplicated.
- Random `in_valid`/`out_ready` toggling over 1000 beats: the scoreboard matches every beat and its order, and `match_cnt` equals the reference model count.
- Saturation, with CNT_W=4:
  - 20 accepted beats with nonzero `out_2` leave `match_cnt`=15;
  - `cnt_clr` asserted together with an incrementing beat gives 0.
- Reset asserted with 2 beats in flight:
  - next cycle `out_valid`=0, `match_cnt`=0, `in_ready`=1;
  - no stale beat emerges afterwards.
- STAGES=1 and STAGES=4 variants: latency is 1 and 4 cycles respectively, and full throughput holds.
